hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hazard_perfcnt.sv | 36 +++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width and hazard-controller state encoding.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/hazard_perfcnt.sv
// Saturating stall/flush cycle counters for the hazard controller.
module hazard_perfcnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (flush_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, memory-wait and fin-drain sequencing.
// Define HAZARD_CTRL_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_usert,
    input  logic              ex_brtaken,
    input  logic              idex_fin,
    input  logic              memwb_fin,
    input  logic              exmem_memreq,
    input  logic              dm_ack,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic              dm_req,
    output logic              halted,
    output logic              mem_fault
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    hz_state_e       saved_q, saved_d;
    hz_state_e       eff_st;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            fault_q, fault_d;
    logic            load_use;
    logic            mem_stall;

    always_comb begin
        load_use  = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_usert && (idex_rt == ifid_rt)));
        mem_stall = exmem_memreq && !dm_ack;
        // The release cycle of a memory wait follows the rules of the interrupted state.
        eff_st    = (state_q == ST_MEMWAIT) ? saved_q : state_q;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        state_d     = state_q;
        saved_d     = saved_q;
        wcnt_d      = wcnt_q;
        fault_d     = fault_q;

        if (state_q == ST_HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            if (state_q == ST_MEMWAIT) begin
                if (wcnt_q == WC_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end else begin
                state_d = ST_MEMWAIT;
                saved_d = state_q;
                wcnt_d  = '0;
            end
        end else begin
            state_d = eff_st;
            if (ex_brtaken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            // A fin on the wrong side of a taken branch is squashed, so it does not start a drain.
            if (eff_st == ST_DRAIN) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                if (memwb_fin) state_d = ST_HALTED;
            end else if (idex_fin && !ex_brtaken) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            wcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            wcnt_q  <= wcnt_d;
            fault_q <= fault_d;
        end
    end

    assign dm_req    = rst_n && (state_q != ST_HALTED) && exmem_memreq;
    assign halted    = (state_q == ST_HALTED);
    assign mem_fault = fault_q;

`ifdef HAZARD_CTRL_PERF_EN
    hazard_perfcnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (!pc_en && (state_q != ST_HALTED)),
        .flush_i     (ifid_flush || idex_flush),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; exercises the counters too when HAZARD_CTRL_PERF_EN is defined.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idex_memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       ifid_usert, ex_brtaken, idex_fin, memwb_fin, exmem_memreq, dm_ack;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_flush;
    logic       dm_req, halted, mem_fault;
    logic [4:0] en_w;
    logic [2:0] fl_w;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic        ps_stall, ps_flush;
    logic [1:0]  ps_sc, ps_fc;

    hazard_perfcnt #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(ps_stall), .flush_i(ps_flush),
        .stall_cnt_o(ps_sc), .flush_cnt_o(ps_fc)
    );
`endif

    hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_usert(ifid_usert),
        .ex_brtaken(ex_brtaken), .idex_fin(idex_fin), .memwb_fin(memwb_fin),
        .exmem_memreq(exmem_memreq), .dm_ack(dm_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .dm_req(dm_req), .halted(halted), .mem_fault(mem_fault)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    assign en_w = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl_w = {ifid_flush, idex_flush, memwb_flush};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idex_memread = 1'b0;
        idex_rt      = 5'd0;
        ifid_rs      = 5'd0;
        ifid_rt      = 5'd0;
        ifid_usert   = 1'b0;
        ex_brtaken   = 1'b0;
        idex_fin     = 1'b0;
        memwb_fin    = 1'b0;
        exmem_memreq = 1'b0;
        dm_ack       = 1'b0;
    endtask

    function automatic logic [31:0] st(input hz_state_e s);
        return 32'(s);
    endfunction

    initial begin
        idle();
`ifdef HAZARD_CTRL_PERF_EN
        ps_stall = 1'b0;
        ps_flush = 1'b0;
`endif
        rst_n = 1'b0;
        exmem_memreq = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_dmreq",  32'(dm_req), 32'd0);
        chk("rst_state",  st(dut.state_q), st(ST_RUN));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault",  32'(mem_fault), 32'd0);
        rst_n = 1'b1;
        exmem_memreq = 1'b0;
        #1;
        chk("idle_en", 32'(en_w), 32'h1f);
        chk("idle_fl", 32'(fl_w), 32'h0);

`ifdef HAZARD_CTRL_PERF_EN
        chk("perf_rst_stall", stall_cnt, 32'd0);
        chk("perf_rst_flush", flush_cnt, 32'd0);
        ex_brtaken = 1'b1;
        ps_stall = 1'b1;
        ps_flush = 1'b1;
        tick();
        tick();
        ex_brtaken = 1'b0;
        exmem_memreq = 1'b1;
        tick();
        tick();
        tick();
        tick();
        ps_stall = 1'b0;
        ps_flush = 1'b0;
        dm_ack = 1'b1;
        #1;
        tick();
        idle();
        #1;
        chk("perf_stall4", stall_cnt, 32'd4);
        chk("perf_flush2", flush_cnt, 32'd2);
        chk("perf_sat_stall", 32'(ps_sc), 32'd3);
        chk("perf_sat_flush", 32'(ps_fc), 32'd3);
`endif

        // Load-use on rs
        idle();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #1;
        chk("lu_en", 32'(en_w), 32'h07);
        chk("lu_fl", 32'(fl_w), 32'h2);
        tick();
        idle();
        #1;
        chk("lu_after_en", 32'(en_w), 32'h1f);
        chk("lu_after_fl", 32'(fl_w), 32'h0);
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        chk("lu_r0_en", 32'(en_w), 32'h1f);
        idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_usert = 1'b0;
        #1;
        chk("lu_nouse_en", 32'(en_w), 32'h1f);
        ifid_usert = 1'b1;
        #1;
        chk("lu_rt_en", 32'(en_w), 32'h07);
        ex_brtaken = 1'b1;
        #1;
        chk("br_lu_fl", 32'(fl_w), 32'h6);
        chk("br_lu_en", 32'(en_w), 32'h1f);
        tick();
        idle();

        // Zero-wait memory access
        exmem_memreq = 1'b1; dm_ack = 1'b1;
        #1;
        chk("zw_en", 32'(en_w), 32'h1f);
        chk("zw_fl", 32'(fl_w), 32'h0);
        chk("zw_dmreq", 32'(dm_req), 32'd1);
        tick();
        chk("zw_state", st(dut.state_q), st(ST_RUN));
        idle();

        // Ack on the fourth request cycle
        exmem_memreq = 1'b1;
        #1;
        chk("ms0_en", 32'(en_w), 32'h00);
        chk("ms0_fl", 32'(fl_w), 32'h1);
        tick();
        chk("ms1_state", st(dut.state_q), st(ST_MEMWAIT));
        chk("ms1_en", 32'(en_w), 32'h00);
        tick();
        chk("ms2_en", 32'(en_w), 32'h00);
        chk("ms2_fl", 32'(fl_w), 32'h1);
        tick();
        dm_ack = 1'b1;
        #1;
        chk("ms_ack_en", 32'(en_w), 32'h1f);
        chk("ms_ack_fl", 32'(fl_w), 32'h0);
        tick();
        idle();
        #1;
        chk("ms_ret_state", st(dut.state_q), st(ST_RUN));
        chk("ms_ret_en", 32'(en_w), 32'h1f);

        // Branch held through a memory wait
        exmem_memreq = 1'b1;
        tick();
        ex_brtaken = 1'b1;
        #1;
        chk("brw_en", 32'(en_w), 32'h00);
        chk("brw_fl", 32'(fl_w), 32'h1);
        tick();
        dm_ack = 1'b1;
        #1;
        chk("brw_rel_en", 32'(en_w), 32'h1f);
        chk("brw_rel_fl", 32'(fl_w), 32'h6);
        tick();
        idle();

        // fin drain to halt, then reset
        idex_fin = 1'b1;
        #1;
        chk("fin_en", 32'(en_w), 32'h0f);
        chk("fin_fl", 32'(fl_w), 32'h4);
        tick();
        idex_fin = 1'b0;
        #1;
        chk("drain_state", st(dut.state_q), st(ST_DRAIN));
        chk("drain_en", 32'(en_w), 32'h0f);
        tick();
        memwb_fin = 1'b1;
        #1;
        chk("drain2_en", 32'(en_w), 32'h0f);
        chk("drain2_halted", 32'(halted), 32'd0);
        tick();
        memwb_fin = 1'b0;
        exmem_memreq = 1'b1;
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_en", 32'(en_w), 32'h00);
        chk("halt_fl", 32'(fl_w), 32'h0);
        chk("halt_dmreq", 32'(dm_req), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_state", st(dut.state_q), st(ST_RUN));
        chk("halt_rst_en", 32'(en_w), 32'h1f);

        // Memory wait during drain returns to drain
        idex_fin = 1'b1;
        tick();
        idex_fin = 1'b0;
        exmem_memreq = 1'b1;
        #1;
        chk("dms_en", 32'(en_w), 32'h00);
        chk("dms_fl", 32'(fl_w), 32'h1);
        tick();
        dm_ack = 1'b1;
        #1;
        chk("dms_rel_en", 32'(en_w), 32'h0f);
        chk("dms_rel_fl", 32'(fl_w), 32'h4);
        tick();
        idle();
        #1;
        chk("dms_state", st(dut.state_q), st(ST_DRAIN));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Timeout: 15 MEMWAIT cycles without ack
        exmem_memreq = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_wait_state", st(dut.state_q), st(ST_MEMWAIT));
            chk("to_wait_fault", 32'(mem_fault), 32'd0);
            tick();
        end
        #1;
        chk("to_fault", 32'(mem_fault), 32'd1);
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_dmreq", 32'(dm_req), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("to_rst_fault", 32'(mem_fault), 32'd0);
        chk("to_rst_halted", 32'(halted), 32'd0);
        chk("to_rst_state", st(dut.state_q), st(ST_RUN));

        // Reset in the middle of a memory wait
        tick();
        chk("mw_state", st(dut.state_q), st(ST_MEMWAIT));
        rst_n = 1'b0;
        tick();
        #1;
        chk("mw_rst_state", st(dut.state_q), st(ST_RUN));
        chk("mw_rst_dmreq", 32'(dm_req), 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
